// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Holds the receiver state encoding, frame width and default timing parameters.
package ps2_pkg;

    localparam int DATA_BITS       = 8;
    localparam int FILTER_LEN_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd count of ones
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_if.sv
// Bundle of the PS/2 line inputs and received-byte outputs.
// The device side (master) drives the lines; the receiver (slave) reports bytes.
interface ps2_if;
    import ps2_pkg::*;

    logic                 ps2_clk;
    logic                 ps2_data;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;
    logic                 rx_err;
    logic                 busy;

    modport master (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_valid, rx_err, busy
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_valid, rx_err, busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes a raw PS/2 line, debounces it with a run-length filter and
// emits a one-cycle strobe when the filtered level falls.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_fall
);

    localparam int              CW       = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    logic          w_level_nxt;
    logic          w_fall_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Run-length filter: the level follows only after FILTER_LEN differing samples
    always_comb begin
        w_level_nxt = r_level;
        w_fall_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (r_sync != r_level) begin
            if (r_cnt == CNT_LAST) begin
                w_level_nxt = r_sync;
                w_fall_nxt  = r_level;
                w_cnt_nxt   = {CW{1'b0}};
            end else begin
                w_cnt_nxt   = r_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_nxt = {CW{1'b0}};
        end
    end

    // Synchronizer and filter state; reset to idle-high so no edge follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_meta  <= i_line;
            r_sync  <= r_meta;
            r_level <= w_level_nxt;
            r_fall  <= w_fall_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Reports each good byte with rx_valid and each bad or stalled frame with rx_err.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    ps2_if.slave bus
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_ZERO = {TW{1'b0}};

    ps2_state_e           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bitcnt;
    logic                 r_par;
    logic [TW-1:0]        r_tcnt;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_data_meta;
    logic                 r_data_sync;

    ps2_state_e           w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]           w_bitcnt_nxt;
    logic                 w_par_nxt;
    logic [TW-1:0]        w_tcnt_nxt;
    logic [DATA_BITS-1:0] w_byte_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 w_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .i_line (bus.ps2_clk),
        .o_fall (w_fall)
    );

    // Data line needs only synchronizing; it is sampled on filtered clock falls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= bus.ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // Next-state, frame assembly and inter-edge timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_tcnt_nxt   = r_tcnt;
        w_byte_nxt   = r_byte;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;

        if (r_state == S_IDLE) begin
            w_tcnt_nxt = TO_ZERO;
        end else if (w_fall) begin
            w_tcnt_nxt = TO_ONE;
        end else if (r_tcnt >= TO_LAST) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_tcnt_nxt  = TO_ZERO;
        end else begin
            w_tcnt_nxt = r_tcnt + TO_ONE;
        end

        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_data_sync) begin
                        w_state_nxt  = S_DATA;
                        w_shift_nxt  = {DATA_BITS{1'b0}};
                        w_bitcnt_nxt = 3'd0;
                        w_tcnt_nxt   = TO_ONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DATA: begin
                    w_shift_nxt  = {r_data_sync, r_shift[DATA_BITS-1:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_PARITY: begin
                    w_par_nxt   = r_data_sync;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (parity_ok(r_shift, r_par) && r_data_sync) begin
                        w_byte_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = TO_ZERO;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = TO_ZERO;
                end
            endcase
        end else begin
            w_par_nxt = r_par;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= {DATA_BITS{1'b0}};
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_tcnt   <= TO_ZERO;
            r_byte   <= {DATA_BITS{1'b0}};
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_byte   <= w_byte_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.rx_byte  = r_byte;
    assign bus.rx_valid = r_valid;
    assign bus.rx_err   = r_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed and random PS/2 frames compared
// against a frame-level model of the odd-parity / stop-bit rules and latency.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FL      = 8;
    localparam int TO      = 200;
    localparam int H       = 20;
    localparam int EXP_LAT = FL + 3;
    localparam int TO_LAT  = FL + 2 + TO;

    logic clk = 1'b0;
    logic rst;
    ps2_if bus ();

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int mon_v = 0;
    int mon_e = 0;
    int mon_both = 0;
    logic [7:0] exp_byte;

    // Strobe-high cycle counters, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) mon_v++;
        if (bus.rx_err === 1'b1) mon_e++;
        if (bus.rx_valid === 1'b1 && bus.rx_err === 1'b1) mon_both++;
    end

    function automatic logic frame_ok(input logic [7:0] b, input logic p, input logic s);
        return ((($countones(b) + int'(p)) % 2) == 1) && (s == 1'b1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        bus.ps2_data = b;
        idle(H);
        bus.ps2_clk = 1'b0;
        idle(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        bus.ps2_clk = 1'b0;
        idle(FL - 2);
        bus.ps2_clk = 1'b1;
        idle(H);
    endtask

    // Sends a whole frame; reports first-strobe latency after the stop-bit fall
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              input int glitch_after,
                              output int lat, output int nv, output int ne);
        logic [9:0] f;
        int v0;
        int e0;
        f = {p, b, 1'b0};
        v0 = mon_v;
        e0 = mon_e;
        lat = 0;
        for (int j = 0; j < 10; j++) begin
            drive_bit(f[j]);
            if (j == glitch_after) glitch();
        end
        bus.ps2_data = s;
        idle(H);
        bus.ps2_clk = 1'b0;
        for (int i = 1; i <= 2 * H; i++) begin
            @(negedge clk);
            if (lat == 0 && (bus.rx_valid === 1'b1 || bus.rx_err === 1'b1)) lat = i;
            if (i == H) bus.ps2_clk = 1'b1;
        end
        idle(2);
        nv = mon_v - v0;
        ne = mon_e - e0;
        bus.ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        idle(3);
        tests++;
        if ({bus.rx_byte, bus.rx_valid, bus.rx_err, bus.busy} !== 11'h000) begin
            failed++;
            $display("FAIL reset_outputs: got byte=%h v=%b e=%b busy=%b, want 00 0 0 0",
                     bus.rx_byte, bus.rx_valid, bus.rx_err, bus.busy);
        end
        rst = 1'b0;
        exp_byte = 8'h00;
        idle(FL + 10);
        tests++;
        if (mon_v + mon_e !== 0 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_no_false_edge: strobes=%0d busy=%b, want 0 0",
                     mon_v + mon_e, bus.busy);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input logic p,
                             input logic s, input int glitch_after);
        int lat;
        int nv;
        int ne;
        logic ok;
        ok = frame_ok(b, p, s);
        if (ok) exp_byte = b;
        send_frame(b, p, s, glitch_after, lat, nv, ne);
        tests++;
        if (nv !== (ok ? 1 : 0) || ne !== (ok ? 0 : 1)) begin
            failed++;
            $display("FAIL %s_strobes: byte=%h p=%b s=%b got valid=%0d err=%0d, want valid=%0d err=%0d",
                     name, b, p, s, nv, ne, ok ? 1 : 0, ok ? 0 : 1);
        end
        tests++;
        if (lat !== EXP_LAT) begin
            failed++;
            $display("FAIL %s_latency: got %0d, want %0d", name, lat, EXP_LAT);
        end
        tests++;
        if (bus.rx_byte !== exp_byte) begin
            failed++;
            $display("FAIL %s_byte: got %h, want %h", name, bus.rx_byte, exp_byte);
        end
    endtask

    task automatic test_known_frames();
        run_frame("f1c_good",   8'h1C, 1'b0, 1'b1, -1);
        run_frame("f1c_badpar", 8'h1C, 1'b1, 1'b1, -1);
        run_frame("ff0_badstop", 8'hF0, 1'b1, 1'b0, -1);
        run_frame("ff0_good",   8'hF0, 1'b1, 1'b1, -1);
    endtask

    task automatic test_random_frames();
        logic [7:0] b;
        logic p;
        logic s;
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
            p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
            run_frame("random", b, p, s, -1);
        end
    endtask

    task automatic test_glitch();
        int v0;
        int e0;
        v0 = mon_v;
        e0 = mon_e;
        glitch();
        idle(H);
        tests++;
        if (bus.busy !== 1'b0 || mon_v != v0 || mon_e != e0) begin
            failed++;
            $display("FAIL glitch_idle: busy=%b strobes=%0d, want 0 0",
                     bus.busy, (mon_v - v0) + (mon_e - e0));
        end
        run_frame("glitch_data", 8'hA7, 1'b1, 1'b1, 3);
    endtask

    task automatic test_timeout();
        logic [4:0] bits;
        int first;
        int v0;
        int e0;
        logic busy_pre;
        logic busy_post;
        bits = 5'b10110;
        v0 = mon_v;
        e0 = mon_e;
        first = 0;
        busy_pre = 1'b0;
        busy_post = 1'b1;
        drive_bit(1'b0);
        for (int j = 0; j < 4; j++) drive_bit(bits[j]);
        bus.ps2_data = bits[4];
        idle(H);
        bus.ps2_clk = 1'b0;
        for (int i = 1; i <= TO_LAT + 4; i++) begin
            @(negedge clk);
            if (first == 0 && bus.rx_err === 1'b1) first = i;
            if (i == H) bus.ps2_clk = 1'b1;
            if (i == TO_LAT - 1) busy_pre = bus.busy;
            if (i == TO_LAT) busy_post = bus.busy;
        end
        bus.ps2_data = 1'b1;
        tests++;
        if (first !== TO_LAT) begin
            failed++;
            $display("FAIL timeout_latency: got %0d, want %0d", first, TO_LAT);
        end
        tests++;
        if (mon_e - e0 !== 1 || mon_v - v0 !== 0) begin
            failed++;
            $display("FAIL timeout_strobes: err=%0d valid=%0d, want 1 0", mon_e - e0, mon_v - v0);
        end
        tests++;
        if ({busy_pre, busy_post} !== 2'b10) begin
            failed++;
            $display("FAIL timeout_busy: before=%b after=%b, want 1 0", busy_pre, busy_post);
        end
        run_frame("after_timeout", 8'h29, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_midframe();
        int v0;
        int e0;
        v0 = mon_v;
        e0 = mon_e;
        drive_bit(1'b0);
        for (int j = 0; j < 4; j++) drive_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.rx_valid, bus.rx_err, bus.rx_byte} !== 11'h000) begin
            failed++;
            $display("FAIL midreset_state: busy=%b v=%b e=%b byte=%h, want 0 0 0 00",
                     bus.busy, bus.rx_valid, bus.rx_err, bus.rx_byte);
        end
        idle(1);
        rst = 1'b0;
        exp_byte = 8'h00;
        idle(3 * H);
        tests++;
        if (mon_v != v0 || mon_e != e0) begin
            failed++;
            $display("FAIL midreset_no_strobe: strobes=%0d, want 0", (mon_v - v0) + (mon_e - e0));
        end
        run_frame("after_reset", 8'h5A, 1'b1, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_known_frames();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_random_frames();
        tests++;
        if (mon_both !== 0) begin
            failed++;
            $display("FAIL strobe_overlap: got %0d cycles, want 0", mon_both);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
